// File: rtl/count_reporter_if.sv
// count_reporter_if: digit inputs, report request and UART/status outputs of the count reporter
//   i_digits_a/b/c : 4-digit BCD count words, [15:12] most significant
//   i_send_now     : single-cycle immediate report request
//   o_tx           : 8N1 UART line, idle high
//   o_busy         : high while a frame is on the line
//   o_frame_done   : one-cycle pulse at the end of a frame
interface count_reporter_if;
    logic [15:0] i_digits_a;
    logic [15:0] i_digits_b;
    logic [15:0] i_digits_c;
    logic        i_send_now;
    logic        o_tx;
    logic        o_busy;
    logic        o_frame_done;
    modport master (
        output i_digits_a, i_digits_b, i_digits_c, i_send_now,
        input  o_tx, o_busy, o_frame_done
    );
    modport slave (
        input  i_digits_a, i_digits_b, i_digits_c, i_send_now,
        output o_tx, o_busy, o_frame_done
    );
endinterface

// File: rtl/count_reporter.sv
// count_reporter: snapshots three BCD count words and sends "A=dddd B=dddd C=dddd\r\n" over 8N1 UART
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : count_reporter_if.slave (digit words, send_now in; tx, busy, frame_done out)
module count_reporter #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int REPORT_CYCLES = 100_000_000
) (
    input logic             clk,
    input logic             reset_n,
    count_reporter_if.slave bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(REPORT_CYCLES);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(REPORT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [4:0]    r_byte;
    logic [TW-1:0] r_timer;
    logic          r_pending;
    logic [47:0]   r_snap;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;
    logic          r_done;

    logic          w_tick;
    logic          w_baud_end;
    logic [175:0]  w_line;
    logic [7:0]    w_byte;

    // Digits above 9 are not valid BCD and are reported as '?'
    function automatic logic [7:0] asc(input logic [3:0] n);
        return (n > 4'd9) ? 8'h3F : {4'h3, n};
    endfunction

    assign w_tick     = r_timer == TIMER_LAST;
    assign w_baud_end = r_baud == BAUD_LAST;

    assign w_line = {8'h41, 8'h3D,
                     asc(r_snap[47:44]), asc(r_snap[43:40]), asc(r_snap[39:36]), asc(r_snap[35:32]),
                     8'h20, 8'h42, 8'h3D,
                     asc(r_snap[31:28]), asc(r_snap[27:24]), asc(r_snap[23:20]), asc(r_snap[19:16]),
                     8'h20, 8'h43, 8'h3D,
                     asc(r_snap[15:12]), asc(r_snap[11:8]), asc(r_snap[7:4]), asc(r_snap[3:0]),
                     8'h0D, 8'h0A};

    // Byte 0 sits in the top octet of the line
    assign w_byte = w_line[(21 - int'(r_byte)) * 8 +: 8];

    assign bus.o_tx         = r_tx;
    assign bus.o_busy       = r_busy;
    assign bus.o_frame_done = r_done;

    // Free-running period timer; never held by an ongoing frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_timer <= '0;
        else          r_timer <= w_tick ? '0 : r_timer + 1'b1;
    end

    // A trigger arriving in the same cycle the request is consumed stays queued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_pending <= 1'b0;
        else          r_pending <= w_tick | bus.i_send_now | (r_pending & (r_state != IDLE));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_snap  <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (r_pending) begin
                    r_state <= START;
                    r_baud  <= '0;
                    r_byte  <= '0;
                    r_snap  <= {bus.i_digits_a, bus.i_digits_b, bus.i_digits_c};
                    r_tx    <= 1'b0;
                    r_busy  <= 1'b1;
                end
                START: if (w_baud_end) begin
                    r_state <= DATA;
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_tx    <= w_byte[0];
                    r_shift <= {1'b0, w_byte[7:1]};
                end else begin
                    r_baud <= r_baud + 1'b1;
                end
                DATA: if (w_baud_end) begin
                    r_baud  <= '0;
                    r_bit   <= r_bit + 1'b1;
                    r_shift <= {1'b0, r_shift[7:1]};
                    r_tx    <= r_shift[0];
                    if (r_bit == 3'd7) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end else begin
                    r_baud <= r_baud + 1'b1;
                end
                STOP: if (w_baud_end) begin
                    r_baud <= '0;
                    if (r_byte == 5'd21) begin
                        r_state <= IDLE;
                        r_byte  <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= START;
                        r_byte  <= r_byte + 1'b1;
                        r_tx    <= 1'b0;
                    end
                end else begin
                    r_baud <= r_baud + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_count_reporter.sv
// tb_count_reporter: directed vectors and multi-cycle scenarios for count_reporter (CLKS_PER_BIT=4, REPORT_CYCLES=5000)
module tb_count_reporter;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   fd_cnt = 0;
    int   starts = 0;
    logic prev_busy = 1'b0;

    count_reporter_if bus();

    count_reporter #(.CLKS_PER_BIT(4), .REPORT_CYCLES(5000)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (bus.o_frame_done === 1'b1) fd_cnt++;
        if (bus.o_busy === 1'b1 && prev_busy !== 1'b1) starts++;
        prev_busy = bus.o_busy;
    end

    typedef struct {
        logic [15:0]  a;
        logic [15:0]  b;
        logic [15:0]  c;
        logic [175:0] exp;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name, input logic [175:0] act, input logic [175:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.i_send_now = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse();
        bus.i_send_now = 1'b1;
        @(negedge clk);
        bus.i_send_now = 1'b0;
    endtask

    task automatic set_digits(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        bus.i_digits_a = a;
        bus.i_digits_b = b;
        bus.i_digits_c = c;
    endtask

    // Waits (bounded) for a start bit, then samples every cycle of one 880-cycle frame at the negedge
    task automatic recv(input int limit, output logic [175:0] got, output int waited, output int errs);
        logic [879:0] bits;
        int pos;
        int b;
        waited = 0;
        errs   = 0;
        got    = '0;
        bits   = '0;
        while (bus.o_tx !== 1'b0 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        if (bus.o_tx !== 1'b0) begin
            errs = 1;
            return;
        end
        for (int s = 0; s < 880; s++) begin
            if (s > 0) @(negedge clk);
            bits[s] = bus.o_tx;
            if (bus.o_busy !== 1'b1) errs++;
        end
        for (int j = 0; j < 220; j++) begin
            for (int k = 1; k < 4; k++) if (bits[4*j+k] !== bits[4*j]) errs++;
            pos = j % 10;
            b   = j / 10;
            if (pos == 0 && bits[4*j] !== 1'b0) errs++;
            else if (pos == 9 && bits[4*j] !== 1'b1) errs++;
            else if (pos > 0 && pos < 9) got[8*(21-b) + pos - 1] = bits[4*j];
        end
    endtask

    // Called at the negedge after the last stop-bit sample
    task automatic check_end(input string name);
        check({name, "_end"}, int'({bus.o_frame_done, bus.o_busy, bus.o_tx}), 3'b101);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [175:0] got;
        int waited;
        int errs;
        int bad;
        int f0;
        int s0;

        vecs[0] = '{16'h1234, 16'h0567, 16'h0012, {"A=1234 B=0567 C=0012", 16'h0D0A}};
        vecs[1] = '{16'h9A0F, 16'h0000, 16'hFFFF, {"A=9?0? B=0000 C=????", 16'h0D0A}};
        vecs[2] = '{16'h9999, 16'h9999, 16'h9999, {"A=9999 B=9999 C=9999", 16'h0D0A}};
        vecs[3] = '{16'hABCD, 16'h8765, 16'h0909, {"A=???? B=8765 C=0909", 16'h0D0A}};

        reset_n = 1'b1;
        bus.i_send_now = 1'b0;
        set_digits(16'h0042, 16'h1000, 16'h9999);
        #2 reset_n = 1'b0;

        // Reset hold with send_now pulses, then the first frame comes only from the first tick
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.i_send_now = i[0];
            if ({bus.o_tx, bus.o_busy, bus.o_frame_done} !== 3'b100) bad++;
        end
        bus.i_send_now = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        recv(6000, got, waited, errs);
        check("reset_hold_outputs", bad, 0);
        check("first_tick_latency", waited, 5001);
        check("first_tick_format", errs, 0);
        check_frame("first_tick_frame", got, {"A=0042 B=1000 C=9999", 16'h0D0A});
        @(negedge clk);
        check_end("first_tick");

        // Table-driven frames via send_now
        for (int v = 0; v < 4; v++) begin
            do_reset();
            set_digits(vecs[v].a, vecs[v].b, vecs[v].c);
            f0 = fd_cnt;
            pulse();
            check($sformatf("vec%0d_idle_before_start", v), int'({bus.o_tx, bus.o_busy}), 2'b10);
            recv(10, got, waited, errs);
            check($sformatf("vec%0d_latency", v), waited, 1);
            check($sformatf("vec%0d_format", v), errs, 0);
            check_frame($sformatf("vec%0d_frame", v), got, vecs[v].exp);
            @(negedge clk);
            check_end($sformatf("vec%0d", v));
            @(negedge clk);
            check($sformatf("vec%0d_done_width", v), int'(bus.o_frame_done), 0);
            check($sformatf("vec%0d_done_count", v), fd_cnt - f0, 1);
        end

        // Inputs changing mid-frame do not affect the frame in flight
        do_reset();
        set_digits(16'h1234, 16'h0567, 16'h0012);
        pulse();
        fork
            recv(10, got, waited, errs);
            begin
                repeat (302) @(negedge clk);
                set_digits(16'h9999, 16'h9999, 16'h9999);
            end
        join
        check("snap_format", errs, 0);
        check_frame("snap_frame1", got, {"A=1234 B=0567 C=0012", 16'h0D0A});
        @(negedge clk);
        check_end("snap");
        pulse();
        recv(10, got, waited, errs);
        check("snap2_format", errs, 0);
        check_frame("snap_frame2", got, {"A=9999 B=9999 C=9999", 16'h0D0A});
        @(negedge clk);

        // Three requests during a frame collapse into one follow-on frame
        do_reset();
        s0 = starts;
        set_digits(16'h0001, 16'h0020, 16'h0300);
        pulse();
        fork
            recv(10, got, waited, errs);
            begin
                repeat (100) @(negedge clk);
                pulse();
                repeat (300) @(negedge clk);
                pulse();
                repeat (300) @(negedge clk);
                pulse();
            end
        join
        check("coal_frame1_format", errs, 0);
        check_frame("coal_frame1", got, {"A=0001 B=0020 C=0300", 16'h0D0A});
        @(negedge clk);
        check_end("coal1");
        recv(10, got, waited, errs);
        check("coal_gap", waited, 1);
        check("coal_frame2_format", errs, 0);
        check_frame("coal_frame2", got, {"A=0001 B=0020 C=0300", 16'h0D0A});
        @(negedge clk);
        check_end("coal2");
        repeat (3000) @(negedge clk);
        check("coal_frame_count", starts - s0, 2);

        // Asynchronous reset during a data bit aborts the frame
        do_reset();
        set_digits(16'h7531, 16'h0246, 16'h8080);
        pulse();
        waited = 0;
        while (bus.o_tx !== 1'b0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        repeat (49) @(negedge clk);
        check("abort_data_bit", int'({bus.o_tx, bus.o_busy}), 2'b01);
        f0 = fd_cnt;
        #1 reset_n = 1'b0;
        #1 check("abort_async", int'({bus.o_tx, bus.o_busy, bus.o_frame_done}), 3'b100);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        recv(6000, got, waited, errs);
        check("abort_no_done", fd_cnt - f0, 0);
        check("abort_tick_latency", waited, 5001);
        check("abort_format", errs, 0);
        check_frame("abort_frame", got, {"A=7531 B=0246 C=8080", 16'h0D0A});
        @(negedge clk);
        check_end("abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_reporter.md
# count_reporter

Serial reporting block for the coincidence counter board. It snapshots the three 4-digit BCD count words (detector A, detector B, coincidence) and transmits them as one ASCII line over an 8N1 UART to the host logger. It sits downstream of the three button counters, reading their `digits` outputs. Frames start on a free-running report period or on an explicit `send_now` pulse.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Minimum 2.
- `REPORT_CYCLES`, 100_000_000: period of the automatic report trigger in clock cycles. Minimum 2.
- `clk` in 1: 100 MHz system clock. All logic is on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `digits_A` in 16: detector A count, 4 BCD nibbles, [15:12] is the most significant digit.
- `digits_B` in 16: detector B count, same format.
- `digits_C` in 16: coincidence count, same format.
- `send_now` in 1: single-cycle request for an immediate report.
- `tx` out 1: UART serial output. Idle level is high.
- `busy` out 1: high while a frame is being transmitted.
- `frame_done` out 1: one-cycle pulse when a frame completes.

## Operation
- **Frame content:** 22 bytes, `A=dddd B=dddd C=dddd` followed by 0x0D 0x0A.
  - Digits are sent most significant first, as ASCII 0x30+nibble.
  - Any nibble greater than 9 is sent as `?` (0x3F).
- **Snapshot:** all 48 digit bits are latched together in the cycle the frame starts. Input changes during a frame do not affect it.
- **UART format:** per byte, one start bit (0), then 8 data bits LSB first, then one stop bit (1). Each bit is held for exactly `CLKS_PER_BIT` cycles. Bytes within a frame are sent back-to-back with no idle gap.
- **State machine:** IDLE → START → DATA → STOP.
  - STOP → START when byte index < 21, with the index incremented.
  - STOP → IDLE after byte 21, pulsing `frame_done`.
  - Counters: baud counter 0..`CLKS_PER_BIT`-1, bit index 0..7, byte index 0..21.
- **Triggers:**
  - The period timer runs 0..`REPORT_CYCLES`-1 and wraps. It emits one tick when it wraps.
  - Either a tick or `send_now` sets a `pending` flag.
  - In IDLE with `pending` set, the block clears `pending`, takes the snapshot and enters START.
- **Coalescing:** any number of triggers during a frame leave a single `pending`. Exactly one further frame follows.
- **Simultaneous events:** a trigger in the same cycle as `frame_done` is kept in `pending`. A tick and `send_now` in the same cycle count as one trigger.
- **Timer independence:** the timer never stops or resets except on `reset_n`, regardless of `busy`.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `frame_done`=0; timer, `pending` and all counters are 0; state is IDLE.
  - Asserting `reset_n` forces these values immediately (asynchronous), including mid-frame. The aborted frame is not resumed.
- **Start latency:** a trigger sampled at edge N puts IDLE→START at edge N+1. `tx` falls and `busy` rises at edge N+1.
- **Frame duration:** `busy` stays high for exactly 220×`CLKS_PER_BIT` cycles.
- **Frame end:** at the edge that ends the last stop bit, `busy` falls and `frame_done` is 1 for exactly one cycle.
- **Back-to-back frames:** a queued frame starts at the edge after `frame_done`. There is one idle-high cycle between frames.
- **First periodic frame:** the first tick occurs `REPORT_CYCLES` cycles after reset release. Ticks repeat every `REPORT_CYCLES` cycles.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `REPORT_CYCLES`=5000. One frame is therefore 880 cycles.
- **Reset hold:** hold `reset_n`=0 for 100 cycles while pulsing `send_now` → `tx`=1, `busy`=0 and `frame_done`=0 throughout. No frame after release until the first tick or a new `send_now`.
- **Basic frame:** set `digits_A`=0x1234, `digits_B`=0x0567, `digits_C`=0x0012, then pulse `send_now` → the UART monitor decodes `A=1234 B=0567 C=0012\r\n`.
  - Every bit is 4 cycles wide.
  - `busy` is high for 880 cycles.
  - Exactly one `frame_done` pulse follows.
- **Snapshot:** change all digit inputs to 0x9999 at cycle 300 of a frame → the current frame is unchanged. The next frame reports `A=9999 B=9999 C=9999`.
- **Non-BCD:** `digits_A`=0x9A0F → the A field is sent as `9?0?`.
- **Coalescing:** pulse `send_now` three times during a frame → exactly one extra frame, with its start bit 1 cycle after `frame_done`. No further frame until the next tick.
- **Reset mid-frame:** drop `reset_n` during a data bit → `tx`=1 and `busy`=0 within the same cycle. After release, the next frame starts 5000 cycles later (first tick) with correct content.
